// File: rtl/hps_pio_out_stream_if.sv
// Avalon-MM slave bus plus outgoing valid/ready stream for hps_pio_out_stream.
// slave = the block itself, master = HPS bridge / fabric sink side.
interface hps_pio_out_stream_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        address;
  logic              chipselect;
  logic              write;
  logic              read;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic [DATA_W-1:0] out_port;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;

  modport slave (
    input  address, chipselect, write, read, writedata, st_ready,
    output readdata, out_port, st_data, st_valid
  );

  modport master (
    output address, chipselect, write, read, writedata, st_ready,
    input  readdata, out_port, st_data, st_valid
  );
endinterface

// File: rtl/hps_pio_out_stream.sv
// HPS-to-fabric word FIFO behind an Avalon-MM slave, show-ahead stream out, plus static OUT register.
// Read latency 1 cycle, no waitrequest; optional irq output under `HPS_PIO_OUT_STREAM_IRQ_EN.
module hps_pio_out_stream #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  hps_pio_out_stream_if.slave   bus
`ifdef HPS_PIO_OUT_STREAM_IRQ_EN
  ,
  output logic                  irq
`endif
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  irq_en_q, irq_en_d;
  logic [DATA_W-1:0]     out_q, out_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic wr_sel, rd_sel, empty, full, pop, push_req, push_ok, flush;
  logic [DATA_W-1:0] status_word, ctrl_word;

  assign wr_sel   = bus.chipselect & bus.write;
  assign rd_sel   = bus.chipselect & bus.read;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign pop      = !empty && bus.st_ready;
  assign push_req = wr_sel && (bus.address == 2'd0);
  assign flush    = wr_sel && (bus.address == 2'd2) && bus.writedata[0];
  // A full FIFO still takes a word when the sink frees a slot in the same cycle.
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    status_word                = '0;
    status_word[CNT_W-1:0]     = count_q;
    status_word[29]            = empty;
    status_word[30]            = full;
    status_word[31]            = ovf_q;
    ctrl_word                  = '0;
    ctrl_word[1]               = irq_en_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    out_d    = out_q;
    rdata_d  = rdata_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    if (push_req && full && !pop) begin
      ovf_d = 1'b1;
    end else if (wr_sel && (bus.address == 2'd1) && bus.writedata[31]) begin
      ovf_d = 1'b0;
    end
    if (wr_sel && (bus.address == 2'd2)) irq_en_d = bus.writedata[1];
    if (wr_sel && (bus.address == 2'd3)) out_d    = bus.writedata;

    if (rd_sel) begin
      case (bus.address)
        2'd0:    rdata_d = mem_q[rd_ptr_q];
        2'd1:    rdata_d = status_word;
        2'd2:    rdata_d = ctrl_word;
        default: rdata_d = out_q;
      endcase
    end
  end

  // Storage is not reset; its contents only matter behind a valid pointer.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= bus.writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      out_q    <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      out_q    <= out_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.st_valid = !empty;
  assign bus.st_data  = mem_q[rd_ptr_q];
  assign bus.readdata = rdata_q;
  assign bus.out_port = out_q;

`ifdef HPS_PIO_OUT_STREAM_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = irq_en_d && ((count_d == '0) || ovf_d);

  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif
endmodule

// File: tb/tb_hps_pio_out_stream.sv
// Bench for hps_pio_out_stream: directed scenarios plus a randomized run against a queue-based model.
module tb_hps_pio_out_stream;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hps_pio_out_stream_if #(.DATA_W(32)) bus ();
`ifdef HPS_PIO_OUT_STREAM_IRQ_EN
  logic irq;
`endif

  hps_pio_out_stream #(.DATA_W(32), .DEPTH_LOG2(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef HPS_PIO_OUT_STREAM_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference state: the FIFO is just a queue of words.
  logic [31:0] q[$];
  logic        m_ovf, m_irq_en, m_irq, rd_known;
  logic [31:0] m_out, m_rd;

  // One bus cycle: drive at negedge, apply the rules at posedge, return at the next negedge.
  task automatic step(input logic [1:0] a, input logic wr, input logic rd,
                      input logic [31:0] wd, input logic rdy);
    logic        pop, full;
    logic [31:0] st, tmp;
    bus.address    = a;
    bus.chipselect = wr | rd;
    bus.write      = wr;
    bus.read       = rd;
    bus.writedata  = wd;
    bus.st_ready   = rdy;
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_ovf = 1'b0; m_irq_en = 1'b0; m_out = '0; m_rd = '0; rd_known = 1'b1;
    end else begin
      pop  = (q.size() > 0) && rdy;
      full = (q.size() == DEPTH);
      if (rd) begin
        rd_known = 1'b1;
        case (a)
          2'd0: if (q.size() > 0) m_rd = q[0]; else rd_known = 1'b0;
          2'd1: begin
            st = '0;
            st[3:0] = 4'(q.size());
            st[29]  = (q.size() == 0);
            st[30]  = full;
            st[31]  = m_ovf;
            m_rd = st;
          end
          2'd2: m_rd = {30'd0, m_irq_en, 1'b0};
          default: m_rd = m_out;
        endcase
      end
      if (wr && a == 2'd2 && wd[0]) begin
        q.delete();
      end else begin
        if (pop) tmp = q.pop_front();
        if (wr && a == 2'd0) begin
          if (!full || pop) q.push_back(wd);
          else m_ovf = 1'b1;
        end
      end
      if (wr && a == 2'd1 && wd[31]) m_ovf = 1'b0;
      if (wr && a == 2'd2) m_irq_en = wd[1];
      if (wr && a == 2'd3) m_out = wd;
    end
    m_irq = m_irq_en && ((q.size() == 0) || m_ovf);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.st_ready   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(2'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(2'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;
    checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata got %h want 0", bus.readdata); end
    checks++; if (bus.out_port !== 32'd0) begin errors++; $display("FAIL reset_out_port got %h want 0", bus.out_port); end
    checks++; if (bus.st_valid !== 1'b0) begin errors++; $display("FAIL reset_st_valid got %b want 0", bus.st_valid); end
    step(2'd1, 1'b0, 1'b1, 32'd0, 1'b0);
    checks++; if (bus.readdata !== 32'h2000_0000) begin errors++; $display("FAIL reset_status got %h want 20000000", bus.readdata); end
  endtask

  task automatic test_out_reg;
    step(2'd3, 1'b1, 1'b0, 32'hA5A5_0001, 1'b0);
    checks++; if (bus.out_port !== 32'hA5A5_0001) begin errors++; $display("FAIL out_port got %h want a5a50001", bus.out_port); end
    step(2'd3, 1'b0, 1'b1, 32'd0, 1'b0);
    checks++; if (bus.readdata !== 32'hA5A5_0001) begin errors++; $display("FAIL out_readback got %h want a5a50001", bus.readdata); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 9; i++) step(2'd0, 1'b1, 1'b0, 32'(i), 1'b0);
    step(2'd1, 1'b0, 1'b1, 32'd0, 1'b0);
    checks++; if (bus.readdata !== 32'hC000_0008) begin errors++; $display("FAIL ovf_status got %h want c0000008", bus.readdata); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.st_valid !== 1'b1 || bus.st_data !== 32'(i)) begin
        errors++; $display("FAIL ovf_drain[%0d] got v=%b d=%h want v=1 d=%h", i, bus.st_valid, bus.st_data, i);
      end
      step(2'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    end
    checks++; if (bus.st_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained_valid got %b want 0", bus.st_valid); end
    step(2'd1, 1'b1, 1'b0, 32'h8000_0000, 1'b0);
    step(2'd1, 1'b0, 1'b1, 32'd0, 1'b0);
    checks++; if (bus.readdata !== 32'h2000_0000) begin errors++; $display("FAIL ovf_clear got %h want 20000000", bus.readdata); end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] last;
    int n;
    for (int i = 0; i < 8; i++) step(2'd0, 1'b1, 1'b0, 32'h100 + 32'(i), 1'b0);
    step(2'd0, 1'b1, 1'b0, 32'h55, 1'b1);
    step(2'd1, 1'b0, 1'b1, 32'd0, 1'b0);
    checks++; if (bus.readdata !== 32'h4000_0008) begin errors++; $display("FAIL fullpp_status got %h want 40000008", bus.readdata); end
    n = 0; last = '0;
    for (int i = 0; i < 20 && bus.st_valid === 1'b1; i++) begin
      last = bus.st_data; n++;
      step(2'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    end
    checks++; if (n != 8 || last !== 32'h55) begin errors++; $display("FAIL fullpp_drain got n=%0d last=%h want n=8 last=00000055", n, last); end
    step(2'd1, 1'b0, 1'b1, 32'd0, 1'b0);
    checks++; if (bus.readdata !== m_rd || m_rd !== 32'h2000_0000) begin errors++; $display("FAIL fullpp_noovf got %h want 20000000", bus.readdata); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) step(2'd0, 1'b1, 1'b0, $urandom, 1'b0);
    step(2'd2, 1'b1, 1'b0, 32'h1, 1'b1);
    checks++; if (bus.st_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", bus.st_valid); end
    step(2'd1, 1'b0, 1'b1, 32'd0, 1'b0);
    checks++; if (bus.readdata !== 32'h2000_0000) begin errors++; $display("FAIL flush_status got %h want 20000000", bus.readdata); end
    step(2'd2, 1'b0, 1'b1, 32'd0, 1'b0);
    checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL flush_ctrl got %h want 0", bus.readdata); end
    step(2'd2, 1'b1, 1'b0, 32'h2, 1'b0);
    step(2'd2, 1'b0, 1'b1, 32'd0, 1'b0);
    checks++; if (bus.readdata !== 32'h2) begin errors++; $display("FAIL ctrl_irqen got %h want 2", bus.readdata); end
    checks++; if (bus.out_port !== m_out) begin errors++; $display("FAIL flush_out_port got %h want %h", bus.out_port, m_out); end
    step(2'd2, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

`ifdef HPS_PIO_OUT_STREAM_IRQ_EN
  task automatic test_irq;
    step(2'd2, 1'b1, 1'b0, 32'h2, 1'b0);
    step(2'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_empty got %b want 1", irq); end
    step(2'd0, 1'b1, 1'b0, 32'hDEAD_0001, 1'b0);
    step(2'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_push got %b want 0", irq); end
    step(2'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    step(2'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_drain got %b want 1", irq); end
    step(2'd2, 1'b1, 1'b0, 32'h0, 1'b0);
    step(2'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_disable got %b want 0", irq); end
  endtask
`endif

  task automatic test_random;
    int op;
    logic rdy;
    for (int c = 0; c < 600; c++) begin
      checks++;
      if (bus.st_valid !== (q.size() > 0)) begin
        errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, bus.st_valid, q.size() > 0);
      end else if (q.size() > 0) begin
        checks++;
        if (bus.st_data !== q[0]) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", c, bus.st_data, q[0]); end
      end
      op  = $urandom_range(0, 19);
      rdy = 1'($urandom_range(0, 2) == 0);
      if (op < 9)       step(2'd0, 1'b1, 1'b0, $urandom, rdy);
      else if (op < 11) step(2'd0, 1'b0, 1'b1, 32'd0, rdy);
      else if (op < 13) step(2'd1, 1'b0, 1'b1, 32'd0, rdy);
      else if (op == 13) step(2'd2, 1'b1, 1'b0, ($urandom & 32'h2) | 32'($urandom_range(0, 3) == 0), rdy);
      else if (op == 14) step(2'd1, 1'b1, 1'b0, $urandom, rdy);
      else if (op == 15) step(2'd3, 1'b1, 1'b0, $urandom, rdy);
      else if (op == 16) step(2'd2, 1'b0, 1'b1, 32'd0, rdy);
      else              step(2'd0, 1'b0, 1'b0, 32'd0, rdy);
      if (rd_known) begin
        checks++;
        if (bus.readdata !== m_rd) begin errors++; $display("FAIL rnd_readdata cyc %0d got %h want %h", c, bus.readdata, m_rd); end
      end
      checks++;
      if (bus.out_port !== m_out) begin errors++; $display("FAIL rnd_out_port cyc %0d got %h want %h", c, bus.out_port, m_out); end
`ifdef HPS_PIO_OUT_STREAM_IRQ_EN
      checks++;
      if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq cyc %0d got %b want %b", c, irq, m_irq); end
`endif
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) step(2'd0, 1'b1, 1'b0, $urandom, 1'b0);
    step(2'd3, 1'b1, 1'b0, 32'h1234_5678, 1'b0);
    reset = 1'b1;
    step(2'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
    reset = 1'b0;
    checks++; if (bus.st_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", bus.st_valid); end
    checks++; if (bus.out_port !== 32'd0) begin errors++; $display("FAIL rstmid_out_port got %h want 0", bus.out_port); end
    step(2'd1, 1'b0, 1'b1, 32'd0, 1'b0);
    checks++; if (bus.readdata !== 32'h2000_0000) begin errors++; $display("FAIL rstmid_status got %h want 20000000", bus.readdata); end
  endtask

  initial begin
    reset          = 1'b1;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.writedata  = '0;
    bus.st_ready   = 1'b0;
    m_ovf = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0; m_out = '0; m_rd = '0; rd_known = 1'b1;
    @(negedge clk);
    test_reset();
    test_out_reg();
    test_overflow();
    test_full_push_pop();
    test_flush();
`ifdef HPS_PIO_OUT_STREAM_IRQ_EN
    test_irq();
`endif
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
